// File: rtl/pc_fetch_unit.sv
// Tiny-CPU instruction-fetch stage: owns the PC, steers the external Adder,
// fetches one instruction per PC over req/ack and offers it to decode over valid/ready.
module pc_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [ADDR_W-1:0]  adder_input1,
  output logic [ADDR_W-1:0]  adder_input2,
  input  logic [ADDR_W-1:0]  adder_output,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                fetch_done_s;
  logic                handshake_s;
  logic [ADDR_W-1:0]   pc_next_s;
  logic [ADDR_W-1:0]   pc_r;
  logic                mem_req_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                instr_valid_r;
  logic [INSTR_W-1:0]  instr_out_r;
  logic [ADDR_W-1:0]   instr_pc_r;

  assign fetch_done_s = (state_r == FETCH) && mem_ack;
  assign handshake_s  = (state_r == HOLD) && instr_valid_r && instr_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = FETCH;
        else        state_next_s = IDLE;
      end
      FETCH: begin
        if (mem_ack) state_next_s = HOLD;
        else         state_next_s = FETCH;
      end
      HOLD: begin
        if (handshake_s) state_next_s = enable ? FETCH : IDLE;
        else             state_next_s = HOLD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Adder operand steering; the branch target only applies while an instruction is held
  always_comb begin
    adder_input1 = pc_r;
    adder_input2 = {{(ADDR_W-1){1'b0}}, 1'b1};
    if ((state_r == HOLD) && branch_taken) begin
      adder_input1 = instr_pc_r;
      adder_input2 = branch_offset;
    end else begin
      adder_input1 = pc_r;
      adder_input2 = {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Next PC: increment on fetch completion, redirect on an accepted taken branch
  always_comb begin
    pc_next_s = pc_r;
    if (fetch_done_s) begin
      pc_next_s = adder_output;
    end else if (handshake_s && branch_taken) begin
      pc_next_s = adder_output;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= {ADDR_W{1'b0}};
      mem_req_r     <= 1'b0;
      mem_addr_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
      instr_out_r   <= {INSTR_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
    end else begin
      pc_r      <= pc_next_s;
      mem_req_r <= (state_next_s == FETCH);
      // Address is captured once on entry to FETCH and held until the ack
      if ((state_next_s == FETCH) && (state_r != FETCH)) begin
        mem_addr_r <= pc_next_s;
      end
      if (fetch_done_s) begin
        instr_out_r   <= mem_rdata;
        instr_pc_r    <= pc_r;
        instr_valid_r <= 1'b1;
      end else if (handshake_s) begin
        instr_valid_r <= 1'b0;
      end
    end
  end

  assign pc          = pc_r;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr_out   = instr_out_r;
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural adder and a ROM whose
// ack is gated by the bench.
module tb_pc_fetch_unit;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] adder_input1;
  logic [7:0] adder_input2;
  logic [7:0] adder_output;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic [7:0] pc;

  logic       ack_en;
  logic [7:0] rom [256];
  int         checks;
  int         failures;

  pc_fetch_unit #(.ADDR_W(8), .INSTR_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adder_input1(adder_input1), .adder_input2(adder_input2), .adder_output(adder_output),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc)
  );

  assign adder_output = adder_input1 + adder_input2;
  assign mem_ack      = mem_req & ack_en;
  assign mem_rdata    = rom[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [7:0] target);
    int n;
    n = 0;
    while (!(instr_valid && instr_pc == target) && n < 1000) begin
      tick();
      n++;
    end
    check("reach_pc", {23'd0, instr_valid, instr_pc}, {23'd0, 1'b1, target});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[255] = 8'h3C;
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_offset = 8'h00; ack_en = 1'b1;
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_iout", instr_out, 8'h00);
    check("rst_ipc", instr_pc, 8'h00);

    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_req", mem_req, 1'b0);

    // First fetch with zero-wait memory
    enable = 1'b1;
    tick();
    check("f0_req", mem_req, 1'b1);
    check("f0_addr", mem_addr, 8'h00);
    check("f0_ain1", adder_input1, 8'h00);
    check("f0_ain2", adder_input2, 8'h01);
    tick();
    check("f0_req_lo", mem_req, 1'b0);
    check("f0_valid", instr_valid, 1'b1);
    check("f0_iout", instr_out, 8'hA5);
    check("f0_ipc", instr_pc, 8'h00);
    check("f0_pc", pc, 8'h01);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", instr_valid, 1'b1);
      check("stall_iout", instr_out, 8'hA5);
      check("stall_ipc", instr_pc, 8'h00);
      check("stall_req", mem_req, 1'b0);
    end
    instr_ready = 1'b1;
    tick();
    check("f1_addr", mem_addr, 8'h01);
    check("f1_req", mem_req, 1'b1);
    check("f1_valid", instr_valid, 1'b0);
    tick();
    check("f1_iout", instr_out, 8'hA4);
    check("f1_pc", pc, 8'h02);

    // Backward branch from 0x10 by -4
    run_to(8'h10);
    check("br_iout", instr_out, 8'hB5);
    branch_taken = 1'b1;
    branch_offset = 8'hFC;
    #1;
    check("br_ain1", adder_input1, 8'h10);
    check("br_ain2", adder_input2, 8'hFC);
    tick();
    branch_taken = 1'b0;
    check("br_addr", mem_addr, 8'h0C);
    check("br_pc", pc, 8'h0C);
    tick();
    check("br_ipc", instr_pc, 8'h0C);
    check("br_iout2", instr_out, 8'hA9);

    // Wrap of the PC at the top of memory
    run_to(8'hFF);
    check("wrap_iout", instr_out, 8'h3C);
    check("wrap_pc", pc, 8'h00);
    tick();
    check("wrap_addr", mem_addr, 8'h00);
    check("wrap_req", mem_req, 1'b1);

    // Delayed ack; enable drops while waiting
    ack_en = 1'b0;
    tick();
    check("wait1_req", mem_req, 1'b1);
    check("wait1_addr", mem_addr, 8'h00);
    enable = 1'b0;
    tick();
    check("wait2_req", mem_req, 1'b1);
    check("wait2_addr", mem_addr, 8'h00);
    tick();
    check("wait3_req", mem_req, 1'b1);
    check("wait3_valid", instr_valid, 1'b0);
    ack_en = 1'b1;
    tick();
    check("late_valid", instr_valid, 1'b1);
    check("late_iout", instr_out, 8'hA5);
    check("late_ipc", instr_pc, 8'h00);
    tick();
    check("stop_valid", instr_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stop_req", mem_req, 1'b0);
    end
    check("stop_pc", pc, 8'h01);

    // Asynchronous reset in the middle of a fetch
    enable = 1'b1;
    ack_en = 1'b0;
    tick();
    check("pre_rst_req", mem_req, 1'b1);
    check("pre_rst_addr", mem_addr, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", mem_req, 1'b0);
    check("arst_valid", instr_valid, 1'b0);
    check("arst_pc", pc, 8'h00);
    check("arst_addr", mem_addr, 8'h00);
    ack_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rs_addr", mem_addr, 8'h00);
    check("rs_req", mem_req, 1'b1);
    tick();
    check("rs_iout", instr_out, 8'hA5);
    check("rs_ipc", instr_pc, 8'h00);
    check("rs_pc", pc, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the Tiny-CPU, sitting directly upstream of the 8-bit Adder.
- Holds the program counter and drives the Adder inputs with PC and an increment or branch offset.
- Takes the Adder sum back as the next PC.
- Fetches one 8-bit instruction per PC from program memory with a req/ack handshake and hands it to decode with a valid/ready handshake.

Parameters:
- ADDR_W, 8, PC / memory address width (must match the Adder width).
- INSTR_W, 8, instruction word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  CPU run; 0 = stop issuing new fetches.
- adder_input1  out  ADDR_W  Adder operand A (PC or instr_pc).
- adder_input2  out  ADDR_W  Adder operand B (1 or branch_offset).
- adder_output  in  ADDR_W  Adder sum, used as next PC.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  ADDR_W  fetch address.
- mem_ack  in  1  memory data valid this cycle.
- mem_rdata  in  INSTR_W  fetched instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts instruction.
- instr_out  out  INSTR_W  instruction word.
- instr_pc  out  ADDR_W  address the instruction came from.
- branch_taken  in  1  decode redirect, sampled only on the instr handshake.
- branch_offset  in  ADDR_W  signed two's-complement offset relative to instr_pc.
- pc  out  ADDR_W  current program counter.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state):
  - pc=0, state=IDLE, mem_req=0, mem_addr=0.
  - instr_valid=0, instr_out=0, instr_pc=0.
  - All registers clear without waiting for clk.
- Adder drive (combinational):
  - When state=HOLD and branch_taken=1: adder_input1=instr_pc, adder_input2=branch_offset.
  - Otherwise: adder_input1=pc, adder_input2=1.
  - Sum is modulo 2^ADDR_W; 0xFF+1 wraps to 0x00, no carry out.
- IDLE state:
  - mem_req=0.
  - If enable=1, go to FETCH next cycle.
- FETCH state:
  - mem_req=1 and mem_addr=pc, both held stable until mem_ack.
  - On mem_ack=1 at a rising edge:
    - instr_out<=mem_rdata, instr_pc<=pc, instr_valid<=1.
    - pc<=adder_output (pc+1), mem_req<=0.
    - Go to HOLD.
  - enable dropping during FETCH does not abort the request; the fetch completes normally.
- HOLD state:
  - instr_valid=1; instr_out and instr_pc stay stable until instr_ready=1.
  - On instr_valid & instr_ready at a rising edge:
    - instr_valid<=0.
    - If branch_taken=1, pc<=adder_output (instr_pc+branch_offset), overriding the prior increment.
    - Next state is FETCH if enable=1, otherwise IDLE.
- Ignored inputs:
  - mem_ack outside FETCH.
  - branch_taken without a handshake.
  - instr_ready while instr_valid=0.
- Throughput with a zero-wait memory (ack in the same cycle as req): one instruction every 2 cycles (FETCH, HOLD).
- Latency: instr_valid rises on the edge after mem_ack.
- Registered outputs: mem_req, mem_addr, instr_* and pc are registered. Only adder_input1/2 are combinational.
- Simultaneous events: if reset coincides with mem_ack or a handshake, reset wins and nothing is latched.

Test Plan:
- Reset, then enable=1; memory acks same cycle with 0xA5 at addr 0 -> mem_req high 1 cycle with mem_addr=0x00; next cycle instr_valid=1, instr_out=0xA5, instr_pc=0x00, pc=0x01.
- Hold instr_ready=0 for 5 cycles after instr_valid -> instr_valid/instr_out/instr_pc stable, mem_req=0 throughout. Then instr_ready=1 -> next mem_addr=0x01.
- Instruction at 0x10 accepted with branch_taken=1, branch_offset=0xFC -> adder_input1=0x10, adder_input2=0xFC during handshake; next mem_addr=0x0C, pc=0x0C.
- Run to pc=0xFF, fetch 0x3C -> instr_pc=0xFF, pc=0x00, next mem_addr=0x00.
- mem_ack delayed 3 cycles, enable dropped on the 2nd wait cycle -> mem_req and mem_addr held until ack. Instruction is delivered; after the handshake state=IDLE and mem_req stays 0.
- Assert reset mid-FETCH between clock edges -> mem_req, instr_valid and pc go to 0 immediately without a clock edge. After release with enable=1, fetch restarts at 0x00.
